// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer for the E stage.
// Owns HI/LO, models unit latency, raises D-stage stalls.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out,
  output logic        md_stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  function automatic logic is_f(
    input logic [31:0] ir,
    input logic [5:0]  f
  );
    return (ir[31:26] == 6'd0) && (ir[5:0] == f);
  endfunction

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi, hi_n;
  logic [31:0] lo, lo_n;
  logic [31:0] phi, phi_n;
  logic [31:0] plo, plo_n;
  logic        nc, nc_n;

  logic e_mult, e_multu, e_div, e_divu;
  logic e_mfhi, e_mflo, e_mthi, e_mtlo;
  logic d_md;
  logic unused_bits;

  assign e_mult  = is_f(IR_E, F_MULT);
  assign e_multu = is_f(IR_E, F_MULTU);
  assign e_div   = is_f(IR_E, F_DIV);
  assign e_divu  = is_f(IR_E, F_DIVU);
  assign e_mfhi  = is_f(IR_E, F_MFHI);
  assign e_mflo  = is_f(IR_E, F_MFLO);
  assign e_mthi  = is_f(IR_E, F_MTHI);
  assign e_mtlo  = is_f(IR_E, F_MTLO);

  // md-type in D: op=0 and func in 0100x0/0100x1/0110xx
  assign d_md = (IR_D[31:26] == 6'd0) &&
                ((IR_D[5:2] == 4'b0100) ||
                 (IR_D[5:2] == 4'b0110));

  assign unused_bits = ^{IR_D[25:6], IR_E[25:6]};

  assign start    = e_mult | e_multu | e_div | e_divu;
  assign busy     = (state == BUSY);
  assign HI       = hi;
  assign LO       = lo;
  assign md_stall = d_md && (start || busy);
  assign md_out   = e_mfhi ? hi :
                    e_mflo ? lo : 32'd0;

  // Arithmetic datapath; divisors forced to 1 on the
  // trap cases so the unit never divides by zero and
  // MIN/-1 naturally yields q=MIN, r=0.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] dsr_s, dsr_u;
  logic signed [31:0] q_s, r_s;
  logic        [31:0] q_u, r_u;
  logic               ovf;

  assign prod_s = $signed({{32{A[31]}}, A}) *
                  $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign ovf    = (A == 32'h8000_0000) &&
                  (B == 32'hFFFF_FFFF);
  assign dsr_s  = ((B == 32'd0) || ovf) ? 32'd1 : B;
  assign dsr_u  = (B == 32'd0) ? 32'd1 : B;
  assign q_s    = $signed(A) / $signed(dsr_s);
  assign r_s    = $signed(A) % $signed(dsr_s);
  assign q_u    = A / dsr_u;
  assign r_u    = A % dsr_u;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      nc    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      phi   <= phi_n;
      plo   <= plo_n;
      nc    <= nc_n;
    end
  end

  // Launch, countdown, commit and mthi/mtlo writes
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    phi_n   = phi;
    plo_n   = plo;
    nc_n    = nc;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = BUSY;
          cnt_n   = (e_div | e_divu) ? DIV_N : MULT_N;
          nc_n    = (e_div | e_divu) && (B == 32'd0);
          unique case (1'b1)
            e_mult:  {phi_n, plo_n} = prod_s;
            e_multu: {phi_n, plo_n} = prod_u;
            e_div: begin
              plo_n = q_s;
              phi_n = r_s;
            end
            e_divu: begin
              plo_n = q_u;
              phi_n = r_u;
            end
            default: ;
          endcase
        end else begin
          if (e_mthi) hi_n = A;
          if (e_mtlo) lo_n = A;
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          if (!nc) begin
            hi_n = phi;
            lo_n = plo;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
